// File: rtl/mem_arbiter.sv
// Purpose : arbitrates instruction fetch and load/store requests onto one
//           single-port word-wide memory bus, with RV32I store lane steering,
//           load extraction/extension and misalign/funct3/timeout errors.
// Latency : grant in IDLE (cycle 0), o_mem_req from cycle 1, ack the cycle after
//           i_mem_ready (min 3 cycles/access); an error at grant acks in cycle 1.
// Backpr. : one transaction outstanding; requesters hold req/addr/data until ack,
//           memory stalls via i_mem_ready, bounded by TIMEOUT cycles.
// Ports   : i_inst_* / o_inst_*  fetch port (req, addr -> ack, data, err)
//           i_data_* / o_data_*  load/store port (req, addr, wdata, funct3, rw -> ack, rdata, err)
//           o_mem_* / i_mem_*    memory bus (req, addr, we, be, wdata <- ready, rdata)
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_req,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic              o_inst_ack,
    output logic [XLEN-1:0]   o_inst_data,
    output logic              o_inst_err,
    input  logic              i_data_req,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [XLEN-1:0]   i_data_wdata,
    input  logic [2:0]        i_funct3,
    input  logic              i_read_write,
    output logic              o_data_ack,
    output logic [XLEN-1:0]   o_data_rdata,
    output logic              o_data_err,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value seen on the last WAIT cycle before the abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_data;  // 1 = data port was served last
    logic              lat_data;   // current grant belongs to the data port
    logic [1:0]        lat_off;
    logic [2:0]        lat_f3;

    logic              any_req;
    logic              grant_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_off;
    logic              grant_err;
    logic [3:0]        st_be;
    logic [XLEN-1:0]   st_wdata;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    // Arbitration, grant-time error check and store lane steering.
    always_comb begin
        any_req    = i_inst_req | i_data_req;
        // Data wins a tie unless it was served last, so neither side starves.
        grant_data = i_data_req & (~i_inst_req | ~last_data);
        sel_addr   = grant_data ? i_data_addr : i_inst_addr;
        sel_off    = sel_addr[1:0];

        grant_err = 1'b0;
        if (grant_data) begin
            case (i_funct3)
                3'b011, 3'b110, 3'b111: grant_err = 1'b1;
                3'b001, 3'b101:         grant_err = sel_off[0];
                3'b010:                 grant_err = |sel_off;
                default:                grant_err = 1'b0;
            endcase
        end else begin
            grant_err = |sel_off;
        end

        st_be    = 4'b1111;
        st_wdata = i_data_wdata;
        if (grant_data && i_read_write) begin
            case (i_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << sel_off;
                    st_wdata = {4{i_data_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << sel_off;
                    st_wdata = {2{i_data_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = i_data_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returning word using the latched offset/funct3.
    always_comb begin
        case (lat_off)
            2'b00:   ld_byte = i_mem_rdata[7:0];
            2'b01:   ld_byte = i_mem_rdata[15:8];
            2'b10:   ld_byte = i_mem_rdata[23:16];
            default: ld_byte = i_mem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (lat_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_data    <= 1'b0;
            lat_data     <= 1'b0;
            lat_off      <= 2'b00;
            lat_f3       <= 3'b000;
            o_inst_ack   <= 1'b0;
            o_inst_data  <= '0;
            o_inst_err   <= 1'b0;
            o_data_ack   <= 1'b0;
            o_data_rdata <= '0;
            o_data_err   <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_we     <= 1'b0;
            o_mem_be     <= 4'b0000;
            o_mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        lat_data <= grant_data;
                        lat_off  <= sel_off;
                        lat_f3   <= i_funct3;
                        cnt      <= '0;
                        if (grant_err) begin
                            // Rejected without touching the memory bus.
                            state <= S_RESP;
                            if (grant_data) begin
                                o_data_ack   <= 1'b1;
                                o_data_err   <= 1'b1;
                                o_data_rdata <= '0;
                            end else begin
                                o_inst_ack  <= 1'b1;
                                o_inst_err  <= 1'b1;
                                o_inst_data <= '0;
                            end
                        end else begin
                            state       <= S_WAIT;
                            o_mem_req   <= 1'b1;
                            o_mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
                            o_mem_we    <= grant_data & i_read_write;
                            o_mem_be    <= st_be;
                            o_mem_wdata <= st_wdata;
                        end
                    end
                end

                S_WAIT: begin
                    // Ready takes priority over an expiring counter.
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        state     <= S_RESP;
                        if (lat_data) begin
                            o_data_ack   <= 1'b1;
                            o_data_err   <= 1'b0;
                            o_data_rdata <= o_mem_we ? '0 : ld_data;
                        end else begin
                            o_inst_ack  <= 1'b1;
                            o_inst_err  <= 1'b0;
                            o_inst_data <= i_mem_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        o_mem_req <= 1'b0;
                        state     <= S_RESP;
                        if (lat_data) begin
                            o_data_ack   <= 1'b1;
                            o_data_err   <= 1'b1;
                            o_data_rdata <= '0;
                        end else begin
                            o_inst_ack  <= 1'b1;
                            o_inst_err  <= 1'b1;
                            o_inst_data <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    o_inst_ack <= 1'b0;
                    o_inst_err <= 1'b0;
                    o_data_ack <= 1'b0;
                    o_data_err <= 1'b0;
                    last_data  <= lat_data;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
